alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle sequencer that borrows the shared `alu_unit` to compute an unsigned 8x8→16 multiply by shift-and-add. While it runs it owns the ALU input mux through `alu_sel` and drives op, operands and carry-in. It reads back `alu_out` and `carry_out`. It sits beside the core's microcode sequencer, which starts it, stalls on `busy`, and collects `product` when `done` pulses.

## Interface
- No parameters; width is fixed at 8-bit operands and a 16-bit product.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ready`  in  1  core stall; when low, no register in this block changes.
- `start`  in  1  request; sampled on a rising edge with `ready`=1 in IDLE or DONE.
- `multiplicand`  in  8  M; captured at start.
- `multiplier`  in  8  Q; captured at start.
- `busy`  out  1  high in ADD/RORH/RORL.
- `done`  out  1  high for exactly the DONE state (one `ready`-qualified cycle).
- `product`  out  16  {P,Q}; held stable from DONE until the next accepted start.
- `alu_sel`  out  1  1 = core ALU mux selects this block's operands; equals `busy`.
- `alu_op`  out  4  ALU op code, using the shared include macros.
- `alu_a`, `alu_b`  out  8  ALU operands.
- `alu_c_in`  out  1  ALU carry-in.
- `alu_dec_add`  out  1  tied 0; multiply is always binary, whatever the D flag is.
- `alu_out`  in  8  ALU result.
- `alu_carry`  in  1  ALU `carry_out`.

## Operation
- Internal registers: P[7:0] (high product), Q[7:0] (low product/multiplier), M[7:0], C (carry), cnt[2:0], and state.
- Reset values: state=IDLE; P=Q=M=0; C=0; cnt=0; `busy`=`done`=`alu_sel`=0; `product`=0.
- ALU drive outputs are combinational from state and registers.
- IDLE and DONE drive `alu_op`=`ALU_PSA`, `alu_a`=`alu_b`=0 and `alu_c_in`=0.
- IDLE/DONE with `start` → load P=0, Q=`multiplier`, M=`multiplicand`, C=0, cnt=0; go to ADD.
- IDLE/DONE without `start`: DONE → IDLE; IDLE stays IDLE.
- ADD:
  - Drive op=`ALU_ADC`, a=P, b=(Q[0] ? M : 0), c_in=0.
  - On the edge: P←`alu_out`, C←`alu_carry`; go to RORH.
- RORH:
  - Drive op=`ALU_ROR`, a=P, c_in=C.
  - The ALU returns {C,P[7:1]} with carry P[0].
  - On the edge: P←`alu_out`, C←`alu_carry`; go to RORL.
- RORL:
  - Drive op=`ALU_ROR`, a=Q, c_in=C.
  - On the edge: Q←`alu_out`. C is don't-care and is cleared to 0.
  - If cnt==7, go to DONE; otherwise cnt←cnt+1 and go to ADD.
- `product`={P,Q} is combinational from the registers.
  - It is valid in DONE.
  - It stays valid in IDLE until the next accepted start, because start reloads P and Q.
- `start` in ADD/RORH/RORL is ignored and not queued.

## Timing
- Fixed latency: 3 cycles per bit × 8 bits = 24 execution cycles.
- With `start` accepted at edge E0 and `ready` held high:
  - `busy` is high E0→E24.
  - `done` is high E24→E25.
  - `product` is valid from E24.
- Each `ready`=0 cycle adds exactly one cycle; state, registers and outputs hold.
- A stall holds the ALU drive outputs stable, so the ALU result is simply recomputed.
- Back-to-back operation: `start` during DONE is accepted at that edge.
  - `done` stays a single cycle; the new operation's ADD follows immediately.
- Reset mid-operation, asynchronous: all outputs return to reset values at once and `alu_sel` drops without waiting for a clock.
- `multiplicand`/`multiplier` matter only at the start edge; they may change freely afterwards.

## Test plan
- 13×11: start with M=0x0D, Q=0x0B → `done` at E24, `product`=0x008F. `alu_op` sequence is ADC,ROR,ROR ×8; `alu_dec_add`=0 throughout.
- 0xFF×0xFF → 0xFE01. Check carry propagation through C on every iteration. Also 0x00×0x5A → 0x0000 and 0x01×0x80 → 0x0080.
- Random `ready` stalls (about 30% low) on 0xA5×0x3C → product 0x26AC. `done` arrives after 24 + stall-count cycles and nothing changes while `ready`=0.
- `start` pulsed with new operands during RORH → ignored; the original operation's product is returned.
- `reset_n` low at cycle 10 of an operation → immediate `busy`=0, `alu_sel`=0, `product`=0. A new start after release gives the correct result.
- Back-to-back: a second start asserted in the DONE cycle → `done` is one cycle only; the second product is correct at E48.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Shift-and-add 8x8->16 unsigned multiply sequencer that borrows the shared ALU.
// Each multiplier bit takes three steps: ADC, ROR of P, ROR of Q. Eight bits give 24 cycles.
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ready,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        alu_sel,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_c_in,
  output logic        alu_dec_add,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry
);

  // These op codes mirror the shared ALU include definitions.
  localparam logic [3:0] ALU_PSA = 4'h0;
  localparam logic [3:0] ALU_ADC = 4'h3;
  localparam logic [3:0] ALU_ROR = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_RORH,
    S_RORL,
    S_DONE
  } state_t;

  state_t      state;
  logic [7:0]  p;
  logic [7:0]  q;
  logic [7:0]  m;
  logic        c;
  logic [2:0]  cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      p     <= '0;
      q     <= '0;
      m     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (ready) begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            p     <= '0;
            q     <= multiplier;
            m     <= multiplicand;
            c     <= 1'b0;
            cnt   <= '0;
            state <= S_ADD;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_ADD: begin
          p     <= alu_out;
          c     <= alu_carry;
          state <= S_RORH;
        end
        S_RORH: begin
          p     <= alu_out;
          c     <= alu_carry;
          state <= S_RORL;
        end
        S_RORL: begin
          q <= alu_out;
          c <= 1'b0;
          if (cnt == 3'd7) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 3'd1;
            state <= S_ADD;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_sel     = busy;
  assign alu_dec_add = 1'b0;
  assign product     = {p, q};

  always_comb begin
    alu_op   = ALU_PSA;
    alu_a    = '0;
    alu_b    = '0;
    alu_c_in = 1'b0;
    case (state)
      S_ADD: begin
        alu_op = ALU_ADC;
        alu_a  = p;
        alu_b  = q[0] ? m : '0;
      end
      S_RORH: begin
        alu_op   = ALU_ROR;
        alu_a    = p;
        alu_c_in = c;
      end
      S_RORL: begin
        alu_op   = ALU_ROR;
        alu_a    = q;
        alu_c_in = c;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: a behavioural ALU plus directed multiply vectors,
// a stepwise shift-and-add reference, stalls, ignored start, mid-run reset and back-to-back.
module tb_alu_mul_seq;

  localparam logic [3:0] OP_PSA = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h3;
  localparam logic [3:0] OP_ROR = 4'hB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ready;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        alu_sel;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_c_in;
  logic        alu_dec_add;
  logic [7:0]  alu_out;
  logic        alu_carry;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ready        (ready),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_sel      (alu_sel),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_c_in     (alu_c_in),
    .alu_dec_add  (alu_dec_add),
    .alu_out      (alu_out),
    .alu_carry    (alu_carry)
  );

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    alu_out   = alu_a;
    alu_carry = 1'b0;
    case (alu_op)
      OP_ADC: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
      OP_ROR: begin
        alu_out   = {alu_c_in, alu_a[7:1]};
        alu_carry = alu_a[0];
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    int          stall_pct;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one multiply, stepping an independent shift-and-add reference alongside the DUT.
  task automatic do_op(input logic [7:0] m, input logic [7:0] q, input int stall_pct,
                       input int inject_at, input logic [15:0] exp);
    logic [7:0]  mp, mq, bval;
    logic        mc, r;
    logic [8:0]  sum;
    logic [39:0] snap;
    int          s, cyc, nstall, bad;
    s = 0; cyc = 0; nstall = 0; bad = 0;
    mp = '0; mq = q; mc = 1'b0;
    @(negedge clk);
    multiplicand = m; multiplier = q; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    multiplicand = 8'($urandom); multiplier = 8'($urandom);
    check("done_single_cycle", 32'(done), 32'd0);
    while (!done && cyc < 300) begin
      if (!busy) bad++;
      if (alu_sel !== busy || alu_dec_add !== 1'b0) bad++;
      case (s % 3)
        0: begin
          bval = mq[0] ? m : 8'd0;
          if (alu_op !== OP_ADC || alu_a !== mp || alu_b !== bval || alu_c_in !== 1'b0) bad++;
        end
        1: if (alu_op !== OP_ROR || alu_a !== mp || alu_c_in !== mc) bad++;
        default: if (alu_op !== OP_ROR || alu_a !== mq || alu_c_in !== mc) bad++;
      endcase
      snap = {busy, done, product, alu_op, alu_a, alu_b, alu_c_in, alu_sel};
      @(negedge clk);
      r = ($urandom_range(0, 99) >= 32'(stall_pct));
      ready = r;
      if (s == inject_at && r) begin
        start = 1'b1; multiplicand = 8'h77; multiplier = 8'h99;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (!r) begin
        nstall++;
        if (snap !== {busy, done, product, alu_op, alu_a, alu_b, alu_c_in, alu_sel}) bad++;
      end else begin
        case (s % 3)
          0: begin
            sum = {1'b0, mp} + {1'b0, (mq[0] ? m : 8'd0)};
            mp = sum[7:0]; mc = sum[8];
          end
          1: begin
            bval = mp;
            mp = {mc, mp[7:1]};
            mc = bval[0];
          end
          default: begin
            mq = {mc, mq[7:1]};
            mc = 1'b0;
          end
        endcase
        s++;
      end
    end
    ready = 1'b1;
    check("step_trace_errors", 32'(bad), 32'd0);
    check("latency", 32'(cyc), 32'(24 + nstall));
    check("done_at_end", 32'(done), 32'd1);
    check("busy_at_end", 32'(busy), 32'd0);
    check("product", 32'(product), 32'(exp));
  endtask

  task automatic after_done(input logic [15:0] exp);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_drops", 32'(done), 32'd0);
    check("product_held_idle", 32'(product), 32'(exp));
    check("idle_alu_op", 32'(alu_op), 32'(OP_PSA));
  endtask

  initial begin
    tbl[0] = '{m: 8'h0D, q: 8'h0B, stall_pct: 0,  exp: 16'h008F};
    tbl[1] = '{m: 8'hFF, q: 8'hFF, stall_pct: 0,  exp: 16'hFE01};
    tbl[2] = '{m: 8'h00, q: 8'h5A, stall_pct: 0,  exp: 16'h0000};
    tbl[3] = '{m: 8'h01, q: 8'h80, stall_pct: 0,  exp: 16'h0080};
    tbl[4] = '{m: 8'hA5, q: 8'h3C, stall_pct: 30, exp: 16'h26AC};
    tbl[5] = '{m: 8'h80, q: 8'hFF, stall_pct: 0,  exp: 16'h7F80};
    tbl[6] = '{m: 8'h0F, q: 8'h10, stall_pct: 0,  exp: 16'h00F0};

    reset_n = 1'b0; ready = 1'b1; start = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_alu_sel", 32'(alu_sel), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_alu_op", 32'(alu_op), 32'(OP_PSA));
    check("reset_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].m, tbl[i].q, tbl[i].stall_pct, -1, tbl[i].exp);
      after_done(tbl[i].exp);
    end

    // Start pulsed while the first RORH is in progress must be ignored.
    do_op(8'h0D, 8'h0B, 0, 1, 16'h008F);
    after_done(16'h008F);

    // Back-to-back: second start lands in the DONE cycle.
    do_op(8'hFF, 8'hFF, 0, -1, 16'hFE01);
    do_op(8'hA5, 8'h3C, 0, -1, 16'h26AC);
    after_done(16'h26AC);

    // Asynchronous reset partway through an operation.
    @(negedge clk);
    multiplicand = 8'hA5; multiplier = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_alu_sel", 32'(alu_sel), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_alu_op", 32'(alu_op), 32'(OP_PSA));
    @(negedge clk);
    reset_n = 1'b1;
    do_op(8'hA5, 8'h3C, 0, -1, 16'h26AC);
    after_done(16'h26AC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
